// File: rtl/e_md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div/accumulate
// with a fixed latency, and supports move-to/from-HI/LO, flush abort and divide-by-zero flag.
module e_md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_valid,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic [WIDTH-1:0] hl_data,
    output logic             busy,
    output logic             md_stall,
    output logic             div_zero
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;
    localparam logic [3:0] OP_MFHI  = 4'd11;
    localparam logic [3:0] OP_MFLO  = 4'd12;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] shi_q, shi_d, slo_q, slo_d;
    logic             sdz_q, sdz_d, dz_q, dz_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic is_start, is_md, is_div;
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, acc, mul_res;
    logic [WIDTH-1:0]   abs_a, abs_b, dvd, dvs, q_mag, r_mag, quo, rem;
    logic               div_signed, neg_q, neg_r, b_zero;

    assign is_start = (md_op >= OP_MULT) && (md_op <= OP_MSUBU);
    assign is_md    = (md_op >= OP_MULT) && (md_op <= OP_MFLO);
    assign is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign busy     = (cnt_q != '0);
    assign md_stall = md_valid && is_md && (busy || is_start);
    assign div_zero = dz_q;

    // Sign-extending to 2*WIDTH makes a plain truncated multiply yield the signed product.
    assign a_sx   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign b_sx   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign a_zx   = {{WIDTH{1'b0}}, src_a};
    assign b_zx   = {{WIDTH{1'b0}}, src_b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign acc    = {hi_q, lo_q};

    always_comb begin
        mul_res = prod_s;
        case (md_op)
            OP_MULTU: mul_res = prod_u;
            OP_MADD:  mul_res = acc + prod_s;
            OP_MADDU: mul_res = acc + prod_u;
            OP_MSUB:  mul_res = acc - prod_s;
            OP_MSUBU: mul_res = acc - prod_u;
            default:  mul_res = prod_s;
        endcase
    end

    // Signed divide on magnitudes; MIN/-1 falls out as MIN with remainder 0.
    assign div_signed = (md_op == OP_DIV);
    assign b_zero     = (src_b == '0);
    assign abs_a      = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b      = src_b[WIDTH-1] ? -src_b : src_b;
    assign dvd        = div_signed ? abs_a : src_a;
    assign dvs        = div_signed ? abs_b : src_b;
    assign q_mag      = b_zero ? '0 : dvd / dvs;
    assign r_mag      = b_zero ? '0 : dvd % dvs;
    assign neg_q      = div_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
    assign neg_r      = div_signed && src_a[WIDTH-1];
    assign quo        = b_zero ? '1 : (neg_q ? -q_mag : q_mag);
    assign rem        = b_zero ? src_a : (neg_r ? -r_mag : r_mag);

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        shi_d = shi_q;
        slo_d = slo_q;
        sdz_d = sdz_q;
        cnt_d = cnt_q;
        dz_d  = 1'b0;
        if (cancel) begin
            cnt_d = '0;
            shi_d = '0;
            slo_d = '0;
            sdz_d = 1'b0;
        end else if (busy) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                hi_d = shi_q;
                lo_d = slo_q;
                dz_d = sdz_q;
            end
        end else if (md_valid) begin
            if (is_start) begin
                cnt_d = is_div ? DIV_CNT : MULT_CNT;
                shi_d = is_div ? rem : mul_res[2*WIDTH-1:WIDTH];
                slo_d = is_div ? quo : mul_res[WIDTH-1:0];
                sdz_d = is_div && b_zero;
            end else if (md_op == OP_MTHI) begin
                hi_d = src_a;
            end else if (md_op == OP_MTLO) begin
                lo_d = src_a;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            shi_q <= '0;
            slo_q <= '0;
            sdz_q <= 1'b0;
            cnt_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            shi_q <= shi_d;
            slo_q <= slo_d;
            sdz_q <= sdz_d;
            cnt_q <= cnt_d;
            dz_q  <= dz_d;
        end
    end

    always_comb begin
        hl_data = '0;
        if (md_op == OP_MFHI) hl_data = hi_q;
        else if (md_op == OP_MFLO) hl_data = lo_q;
    end

endmodule

// File: tb/tb_e_md_unit.sv
// Self-checking bench for e_md_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_e_md_unit;

    logic        clk;
    logic        rst;
    logic        md_valid;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic [31:0] hl_data;
    logic        busy;
    logic        md_stall;
    logic        div_zero;

    int checks;
    int failures;
    logic [31:0] exp_hi, exp_lo;
    logic [31:0] rd_hi, rd_lo;

    e_md_unit dut (
        .clk      (clk),
        .rst      (rst),
        .md_valid (md_valid),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .hl_data  (hl_data),
        .busy     (busy),
        .md_stall (md_stall),
        .div_zero (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: result as {HI,LO} computed directly from the arithmetic rules.
    function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hl);
        longint sa, sb, q, r;
        logic [63:0] ps, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ps = sa * sb;
        pu = {32'b0, a} * {32'b0, b};
        case (op)
            4'd1: return ps;
            4'd2: return pu;
            4'd5: return hl + ps;
            4'd6: return hl + pu;
            4'd7: return hl - ps;
            4'd8: return hl - pu;
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return hl;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic c);
        md_valid = v;
        md_op    = op;
        src_a    = a;
        src_b    = b;
        cancel   = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readHL();
        applyStimulus(1'b1, 4'd11, 32'd0, 32'd0, 1'b0);
        rd_hi = hl_data;
        applyStimulus(1'b1, 4'd12, 32'd0, 32'd0, 1'b0);
        rd_lo = hl_data;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic doStartOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] expRes;
        logic        dz;
        int          lat;
        expRes = refResult(op, a, b, {exp_hi, exp_lo});
        lat    = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        dz     = (op == 4'd3 || op == 4'd4) && (b == 32'd0);
        applyStimulus(1'b1, op, a, b, 1'b0);
        checkOutput("issue_stall", md_stall, 1);
        checkOutput("issue_idle", busy, 0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 1; i <= lat; i++) begin
            checkOutput("busy_during", busy, 1);
            checkOutput("dz_during", div_zero, 0);
            if (i == lat) begin
                readHL();
                checkOutput("hl_hold", {rd_hi, rd_lo}, {exp_hi, exp_lo});
            end
            tick();
        end
        checkOutput("busy_fall", busy, 0);
        checkOutput("dz_commit", div_zero, dz);
        {exp_hi, exp_lo} = expRes;
        readHL();
        checkOutput("hl_commit", {rd_hi, rd_lo}, expRes);
        tick();
        checkOutput("dz_one_cycle", div_zero, 0);
    endtask

    task automatic doMove(input logic [3:0] op, input logic [31:0] a);
        applyStimulus(1'b1, op, a, 32'd0, 1'b0);
        checkOutput("move_nostall", md_stall, 0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("move_busy", busy, 0);
        if (op == 4'd9) exp_hi = a;
        else exp_lo = a;
        readHL();
        checkOutput("move_hl", {rd_hi, rd_lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [31:0] a, b, a2, b2;
        logic [63:0] r1, r2;
        int          stallCount;
        logic [3:0]  op;

        checks   = 0;
        failures = 0;
        exp_hi   = 32'd0;
        exp_lo   = 32'd0;
        rst      = 1'b1;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dz", div_zero, 0);
        checkOutput("rst_stall", md_stall, 0);
        readHL();
        checkOutput("rst_hl", {rd_hi, rd_lo}, 64'd0);

        $display("[TB] directed arithmetic");
        doStartOp(4'd1, 32'hFFFF_FFFE, 32'd3);
        checkOutput("mult_lit", {rd_hi, rd_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        applyStimulus(1'b1, 4'd11, 32'd0, 32'd0, 1'b0);
        checkOutput("mfhi_nostall", md_stall, 0);
        checkOutput("mfhi_data", hl_data, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("nop_hl_zero", hl_data, 0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

        doStartOp(4'd4, 32'd7, 32'd0);
        checkOutput("divu0_lit", {rd_hi, rd_lo}, {32'd7, 32'hFFFF_FFFF});
        doStartOp(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div_ovf_lit", {rd_hi, rd_lo}, {32'd0, 32'h8000_0000});

        doMove(4'd9, 32'h0000_0001);
        doMove(4'd10, 32'hFFFF_FFFF);
        doStartOp(4'd6, 32'd1, 32'd1);
        checkOutput("maddu_lit", {rd_hi, rd_lo}, {32'd2, 32'd0});
        doStartOp(4'd7, 32'd1, 32'd2);
        checkOutput("msub_lit", {rd_hi, rd_lo}, {32'd1, 32'hFFFF_FFFE});

        $display("[TB] cancel cases");
        applyStimulus(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            checkOutput("cxl_busy", busy, 1);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("cxl_busy4", busy, 1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("cxl_drop", busy, 0);
        checkOutput("cxl_dz", div_zero, 0);
        readHL();
        checkOutput("cxl_hl", {rd_hi, rd_lo}, {exp_hi, exp_lo});

        applyStimulus(1'b1, 4'd3, 32'd5, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (9) tick();
        checkOutput("cxl_last_busy", busy, 1);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("cxl_last_drop", busy, 0);
        checkOutput("cxl_last_dz", div_zero, 0);
        readHL();
        checkOutput("cxl_last_hl", {rd_hi, rd_lo}, {exp_hi, exp_lo});
        tick();
        checkOutput("cxl_last_dz2", div_zero, 0);

        applyStimulus(1'b1, 4'd1, 32'd3, 32'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("cxl_blocks_start", busy, 0);
        applyStimulus(1'b1, 4'd9, 32'hDEAD_BEEF, 32'd0, 1'b1);
        tick();
        readHL();
        checkOutput("cxl_blocks_move", {rd_hi, rd_lo}, {exp_hi, exp_lo});

        $display("[TB] stall and back-to-back");
        a  = $urandom;
        b  = $urandom;
        r1 = refResult(4'd1, a, b, {exp_hi, exp_lo});
        stallCount = 0;
        applyStimulus(1'b1, 4'd1, a, b, 1'b0);
        if (md_stall) stallCount++;
        tick();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 4'd12, 32'd0, 32'd0, 1'b0);
            if (md_stall) stallCount++;
            tick();
        end
        checkOutput("mflo_release", md_stall, 0);
        checkOutput("stall_cycles", stallCount, 6);
        checkOutput("mflo_new", hl_data, r1[31:0]);
        {exp_hi, exp_lo} = r1;
        a2 = $urandom;
        b2 = $urandom;
        r2 = refResult(4'd1, a2, b2, r1);
        applyStimulus(1'b1, 4'd1, a2, b2, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("b2b_accept", busy, 1);
        repeat (5) tick();
        checkOutput("b2b_done", busy, 0);
        {exp_hi, exp_lo} = r2;
        readHL();
        checkOutput("b2b_hl", {rd_hi, rd_lo}, r2);

        $display("[TB] randomized ops");
        for (int n = 0; n < 30; n++) begin
            op = 4'($urandom_range(1, 10));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (op <= 4'd8) doStartOp(op, a, b);
            else doMove(op, a);
        end

        $display("[TB] async reset mid-op");
        doMove(4'd9, 32'h1234_5678);
        doMove(4'd10, 32'h9ABC_DEF0);
        applyStimulus(1'b1, 4'd3, 32'd50, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_dz", div_zero, 0);
        readHL();
        checkOutput("arst_hl", {rd_hi, rd_lo}, 64'd0);
        tick();
        rst = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        repeat (12) tick();
        checkOutput("arst_no_commit_busy", busy, 0);
        readHL();
        checkOutput("arst_no_commit_hl", {rd_hi, rd_lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e_md_unit.md
Name: e_md_unit

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core.
- Owns the HI/LO registers and executes the mult/div/accumulate and move-to/from-HI/LO operations with configurable latency.
- Adds abort-on-flush, a defined divide-by-zero result with a flag, and an unsigned accumulate mode.
- Drives the E-stage stall request while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_LAT, 5, cycles from accepted mult/madd/msub start to HI/LO commit (>=1).
- DIV_LAT, 10, cycles from accepted div start to HI/LO commit (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- md_valid  input  1  md_op holds a valid instruction in E this cycle
- md_op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO, 11 MFHI, 12 MFLO; 13-15 treated as NOP
- src_a  input  WIDTH  rs operand (also the MTHI/MTLO data)
- src_b  input  WIDTH  rt operand
- cancel  input  1  flush: abort any in-flight op and block any start this cycle
- hl_data  output  WIDTH  MFHI → HI, MFLO → LO, otherwise 0 (combinational)
- busy  output  1  operation in flight
- md_stall  output  1  combinational stall request to the pipeline
- div_zero  output  1  one-cycle pulse in the commit cycle of a DIV/DIVU with src_b==0

Behaviour:
- Reset (async): HI=0, LO=0, counter=0, staged result=0, busy=0, div_zero=0.
- busy is defined as counter!=0.
- Start classes:
  - Start ops: 1-8.
  - Move ops: 9-12.
  - md-class: start ops plus move ops.
- Start accept condition: md_valid && start op && !busy && !cancel.
  - On that edge, the full result is computed and stored in staging registers sHI/sLO.
  - The counter loads MULT_LAT (ops 1,2,5-8) or DIV_LAT (ops 3,4).
- Busy: each edge with counter>0 decrements the counter.
  - On the edge where counter==1, HI<=sHI and LO<=sLO.
  - busy is high for exactly LAT cycles after the accept edge.
  - New HI/LO are visible in the cycle busy falls.
- Back-to-back: a start op presented in the first cycle busy==0 is accepted.
- md_stall = md_valid && md-class && (busy || start op).
  - The issuing start op stalls its successor through E for LAT+1 cycles in total.
  - MFHI/MFLO/MTHI/MTLO presented while busy stall until busy==0.
- MTHI/MTLO: when md_valid && !busy && !cancel, write src_a into HI/LO at the edge. No latency; busy stays low.
- Arithmetic:
  - MULT: signed WIDTH×WIDTH → 2·WIDTH.
  - MULTU: unsigned WIDTH×WIDTH → 2·WIDTH.
  - MADD/MSUB: {HI,LO} ± signed product.
  - MADDU/MSUBU: {HI,LO} ± unsigned product.
  - All accumulates wrap modulo 2^(2·WIDTH).
  - Accumulates use HI/LO as committed at the accept edge.
- Division: LO=quotient, HI=remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case DIV of MIN by -1: LO=MIN, HI=0.
  - Divide by zero (DIV/DIVU with src_b==0): LO=all ones, HI=src_a, div_zero=1 on the commit edge only.
- Cancel:
  - While busy: counter<=0 at the edge; HI/LO keep their previous values; staged result discarded; no div_zero pulse.
  - If cancel arrives in the cycle counter==1, cancel wins and there is no commit.
  - Cancel with idle unit: blocks start and move writes; HI/LO unchanged.
- Reset mid-operation: everything returns to reset values immediately; no commit.
- hl_data is driven regardless of busy. The pipeline ignores it while md_stall=1.

Test Plan:
- Reset, then MULT with src_a=0xFFFFFFFE (-2), src_b=3 → busy for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA on the 5th edge; MFHI then returns 0xFFFFFFFF with md_stall=0.
- DIVU 7/0 → after 10 cycles LO=0xFFFFFFFF, HI=7; div_zero high for exactly one cycle. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- MTHI 0x00000001, MTLO 0xFFFFFFFF, then MADDU 1×1 → HI=2, LO=0. Then MSUB 1×2 → HI=1, LO=0xFFFFFFFE.
- DIV 100/7 started, cancel asserted on the 4th busy cycle → busy drops the next cycle; HI/LO unchanged; no div_zero pulse. Also cancel in the counter==1 cycle → no commit.
- MULT followed immediately by MFLO → md_stall high for 6 cycles in total; MFLO returns the new LO. A second MULT issued the cycle busy falls is accepted with no idle gap.
- Assert rst asynchronously mid-DIV → busy, HI, LO and div_zero all 0 immediately, without waiting for a clock edge.
